sb_tx_arbiter: RTL and testbench
================================

Name: sb_tx_arbiter

Overview:
- Schedules whole sideband transactions from several requesters onto the single sideband transmit serializer input, in the sb_clk domain.
- Requester 0 is the link-training (LT) transaction source and has strict priority. The remaining requesters (AT transactions, config-space responses) share the path round-robin.
- Each grant covers an entire transaction: a byte stream of declared length with valid/ready flow control.
- Followed by a fixed idle gap before the next transaction.

Parameters:
- NUM_REQ, 3, number of requesters (>=2); index 0 is strict-priority.
- DATA_W, 8, sideband byte width.
- MAX_LEN, 16, maximum transaction length in bytes; LEN_W = $clog2(MAX_LEN+1).
- GAP_CYCLES, 2, idle cycles inserted after each transaction (0 allowed).
- TIMEOUT_CYC, 64, stall limit; used only with SB_ARB_TIMEOUT_EN.

Ports:
- sb_clk  in  1  sideband clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  transaction request, one bit per requester.
- req_len_i  in  NUM_REQ*LEN_W  per-requester byte count; slice i belongs to requester i.
- req_data_i  in  NUM_REQ*DATA_W  per-requester data byte.
- req_valid_i  in  NUM_REQ  per-requester data valid.
- req_ready_o  out  NUM_REQ  per-requester data ready.
- gnt_o  out  NUM_REQ  one-hot grant.
- tx_data_o  out  DATA_W  byte to serializer.
- tx_valid_o  out  1  byte valid.
- tx_last_o  out  1  final byte of transaction.
- tx_ready_i  in  1  serializer ready.
- busy_o  out  1  high in any state other than IDLE.
- abort_o  out  1  one-cycle abort pulse; tied 0 without the macro.

Behaviour:
- Reset: asserting rst forces all outputs to 0 immediately, regardless of clock.
  - State returns to IDLE; byte counter and gap counter clear.
  - Round-robin pointer resets so that requester 1 is next in line.
- States: IDLE, XFER, GAP.
- IDLE:
  - busy_o=0, gnt_o=0.
  - On a clock edge with any req_i high: if req_i[0]=1, requester 0 wins. Otherwise the winner is the first requester with req_i high, searching upward from the pointer and wrapping within 1..NUM_REQ-1.
  - On that edge: register gnt_o, latch the winner's req_len_i, move to XFER. Grant is therefore visible one cycle after the request is sampled.
  - A latched length of 0 is treated as 1.
- XFER (g = granted index):
  - Combinational forwarding: tx_data_o = req_data_i[g], tx_valid_o = req_valid_i[g], req_ready_o[g] = tx_ready_i. All other req_ready_o bits are 0.
  - Byte counter increments on each tx_valid_o && tx_ready_i.
  - tx_last_o = tx_valid_o && (count == len-1).
  - The handshake of the last byte moves the FSM to GAP; gnt_o drops on the next cycle.
  - Deassertion of req_i mid-transfer is ignored; the transfer always completes len bytes.
  - With tx_ready_i low, the counter holds and the requester must hold its data stable. With req_valid_i low, nothing is transferred.
- GAP:
  - gnt_o=0, tx_valid_o=0, busy_o=1.
  - Stays GAP_CYCLES cycles, then moves to IDLE. With GAP_CYCLES=0, the FSM goes straight from XFER to IDLE.
- Pointer:
  - Updates to g+1 (wrapping to 1) only when a transfer by requester g>=1 completes or aborts.
  - Grants to requester 0 leave it unchanged.
- Requests arriving during XFER/GAP are arbitrated only when the FSM is back in IDLE; no request is dropped while req_i stays high.
- Continuous req_i[0] can starve the other requesters; this is accepted by design, since LT traffic is bounded.

Optional Feature:
- Macro SB_ARB_TIMEOUT_EN.
- Defined:
  - In XFER, a stall counter counts consecutive cycles with req_valid_i[g]=0 and clears on any cycle with req_valid_i[g]=1.
  - When the count reaches TIMEOUT_CYC, abort_o pulses high for exactly one cycle, tx_valid_o and tx_last_o are forced 0, and the FSM enters GAP.
  - The pointer advances as on normal completion.
- Undefined: no stall counter, abort_o is constantly 0, and XFER waits indefinitely for data.

Test Plan:
- Single transfer: req_i=3'b010, len=3, bytes A1,A2,A3, tx_ready_i=1 -> gnt_o=3'b010 one cycle later; A1,A2,A3 on consecutive cycles; tx_last_o only with A3; busy_o low 2 cycles after A3.
- Priority: req_i[0] and req_i[2] raised in the same cycle, both len=2 -> requester 0's 2 bytes, then 2 gap cycles, then gnt_o=3'b100 and requester 2's bytes.
- Round-robin: req_i[1] and req_i[2] held high, len=1 each -> grant order 1,2,1,2 across 4 transactions; requester 0 never granted.
- Backpressure: len=4, tx_ready_i low for 5 cycles after byte 2 -> byte 3 held stable on tx_data_o, req_ready_o[g]=0 throughout the stall; exactly 4 handshakes; tx_last_o on byte 4.
- Reset mid-transfer: rst pulsed after 2 of 4 bytes -> all outputs 0 in the same cycle; after release with req_i[1] high, a full 4-byte transfer starting from byte 1.
- Timeout: macro on, TIMEOUT_CYC=8, req_valid_i low after byte 1 -> abort_o pulse on the 8th stalled cycle, gnt_o drops the next cycle, next grant goes to requester 2. Same stimulus with macro off -> gnt_o held, abort_o=0.

Source files
------------

// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: requester 0 has strict priority, the rest share round-robin; whole transactions.
// Define SB_ARB_TIMEOUT_EN to enable the stall timeout / abort path.
module sb_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 8,
  parameter int MAX_LEN     = 16,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 64,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                      sb_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_valid_o,
  output logic                      tx_last_o,
  input  logic                      tx_ready_i,
  output logic                      busy_o,
  output logic                      abort_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [GAP_W-1:0]   gap_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [LEN_W-1:0]   win_len;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               in_xfer;
  logic               hs;
  logic               timeout;
  logic [IDX_W-1:0]   ptr_next;

  // Winner search: requester 0 first, then upward from ptr_q wrapping within 1..NUM_REQ-1.
  always_comb begin : arb
    int               c;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    c         = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_len   = '0;
    if (req_i[0]) begin
      win_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        c = int'(ptr_q) + k;
        if (c >= NUM_REQ) c = c - (NUM_REQ - 1);
        cand = IDX_W'(c);
        if (!win_found && req_i[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_len = req_len_i[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin : fwd_mux
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_data  = req_data_i[i*DATA_W +: DATA_W];
        sel_valid = req_valid_i[i];
      end
    end
  end

  assign in_xfer     = (state_q == XFER);
  assign tx_valid_o  = in_xfer && sel_valid;
  assign tx_data_o   = in_xfer ? sel_data : '0;
  assign tx_last_o   = tx_valid_o && (cnt_q == len_q - 1'b1);
  assign req_ready_o = in_xfer ? (gnt_q & {NUM_REQ{tx_ready_i}}) : '0;
  assign hs          = tx_valid_o && tx_ready_i;
  assign gnt_o       = gnt_q;
  assign busy_o      = (state_q != IDLE);
  assign ptr_next    = (idx_q == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : idx_q + 1'b1;

`ifdef SB_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q;

  // Fires on the TIMEOUT_CYC-th consecutive cycle without valid data.
  assign timeout = in_xfer && !sel_valid && (stall_q == STALL_W'(TIMEOUT_CYC - 1));
  assign abort_o = timeout;

  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!in_xfer || sel_valid || timeout) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign abort_o = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(1);
      len_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= XFER;
            gnt_q   <= NUM_REQ'(1) << win_idx;
            idx_q   <= win_idx;
            len_q   <= (win_len == '0) ? LEN_W'(1) : win_len;
            cnt_q   <= '0;
          end
        end
        XFER: begin
          if (timeout || (hs && tx_last_o)) begin
            gnt_q <= '0;
            if (idx_q != '0) ptr_q <= ptr_next;
            gap_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (hs) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else                   gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter: cycle-trace vector table plus hand-written multi-cycle sequences.
module tb_sb_tx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 5;

  logic                      sb_clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*LEN_W-1:0]  req_len_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [DATA_W-1:0]         tx_data_o;
  logic                      tx_valid_o;
  logic                      tx_last_o;
  logic                      tx_ready_i;
  logic                      busy_o;
  logic                      abort_o;

  logic [LEN_W-1:0] len0, len1, len2;
  logic [3:0]       dlo;

  // Lane i carries byte {A+i, dlo}: lane0 = Ax, lane1 = Bx, lane2 = Cx.
  assign req_len_i  = {len2, len1, len0};
  assign req_data_i = {4'hC, dlo, 4'hB, dlo, 4'hA, dlo};

  always #5 sb_clk = ~sb_clk;

  sb_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_LEN(16), .GAP_CYCLES(2), .TIMEOUT_CYC(8)
  ) dut (
    .sb_clk(sb_clk), .rst(rst), .req_i(req_i), .req_len_i(req_len_i),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .gnt_o(gnt_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
    .tx_ready_i(tx_ready_i), .busy_o(busy_o), .abort_o(abort_o)
  );

  typedef struct {
    logic [2:0] req;
    logic [2:0] vld;
    logic [3:0] dlo;
    logic [2:0] e_gnt;
    logic       e_vld;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_busy;
    logic [2:0] e_rdy;
  } vec_t;

  vec_t vecs[18];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic to_pos();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge sb_clk);
  endtask

  // Returns at the negedge of the first cycle with a grant visible, or after the budget expires.
  task automatic wait_gnt(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      to_neg();
      if (gnt_o != '0) break;
      to_pos();
    end
    check({nm, "_grant_seen"}, 32'(gnt_o != '0), 32'd1);
  endtask

  int hs_cnt;

  initial begin
    // Single transfer (req 1, len 3), then priority (req 0 and 2 together), then req 2 with a valid bubble.
    vecs[0]  = '{3'b010, 3'b010, 4'h1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{3'b000, 3'b010, 4'h1, 3'b010, 1'b1, 8'hB1, 1'b0, 1'b1, 3'b010};
    vecs[2]  = '{3'b000, 3'b010, 4'h2, 3'b010, 1'b1, 8'hB2, 1'b0, 1'b1, 3'b010};
    vecs[3]  = '{3'b000, 3'b010, 4'h3, 3'b010, 1'b1, 8'hB3, 1'b1, 1'b1, 3'b010};
    vecs[4]  = '{3'b101, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 3'b000};
    vecs[5]  = '{3'b101, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 3'b000};
    vecs[6]  = '{3'b101, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000};
    vecs[7]  = '{3'b100, 3'b101, 4'h1, 3'b001, 1'b1, 8'hA1, 1'b0, 1'b1, 3'b001};
    vecs[8]  = '{3'b100, 3'b101, 4'h2, 3'b001, 1'b1, 8'hA2, 1'b1, 1'b1, 3'b001};
    vecs[9]  = '{3'b100, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 3'b000};
    vecs[10] = '{3'b100, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 3'b000};
    vecs[11] = '{3'b100, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000};
    vecs[12] = '{3'b000, 3'b000, 4'h5, 3'b100, 1'b0, 8'hC5, 1'b0, 1'b1, 3'b100};
    vecs[13] = '{3'b000, 3'b100, 4'h1, 3'b100, 1'b1, 8'hC1, 1'b0, 1'b1, 3'b100};
    vecs[14] = '{3'b000, 3'b100, 4'h2, 3'b100, 1'b1, 8'hC2, 1'b1, 1'b1, 3'b100};
    vecs[15] = '{3'b000, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 3'b000};
    vecs[16] = '{3'b000, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 3'b000};
    vecs[17] = '{3'b000, 3'b000, 4'h0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000};

    rst = 1'b1; req_i = '0; req_valid_i = '0; tx_ready_i = 1'b1;
    len0 = 5'd2; len1 = 5'd3; len2 = 5'd2; dlo = 4'h0;
    repeat (2) @(posedge sb_clk);
    #1;
    check("rst_gnt",   32'(gnt_o), 0);
    check("rst_busy",  32'(busy_o), 0);
    check("rst_valid", 32'(tx_valid_o), 0);
    check("rst_ready", 32'(req_ready_o), 0);
    check("rst_abort", 32'(abort_o), 0);
    rst = 1'b0;

    // ---------------- table-driven trace ----------------
    for (int i = 0; i < 18; i++) begin
      req_i = vecs[i].req; req_valid_i = vecs[i].vld; dlo = vecs[i].dlo;
      to_neg();
      check($sformatf("vec%0d_gnt", i),   32'(gnt_o),       32'(vecs[i].e_gnt));
      check($sformatf("vec%0d_valid", i), 32'(tx_valid_o),  32'(vecs[i].e_vld));
      check($sformatf("vec%0d_last", i),  32'(tx_last_o),   32'(vecs[i].e_last));
      check($sformatf("vec%0d_busy", i),  32'(busy_o),      32'(vecs[i].e_busy));
      check($sformatf("vec%0d_ready", i), 32'(req_ready_o), 32'(vecs[i].e_rdy));
      if (vecs[i].e_gnt != 3'b000)
        check($sformatf("vec%0d_data", i), 32'(tx_data_o), 32'(vecs[i].e_data));
      to_pos();
    end

    // ---------------- round-robin, len 1 and len 0 (treated as 1) ----------------
    begin
      logic [2:0] exp_g[4];
      exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b010; exp_g[3] = 3'b100;
      len1 = 5'd1; len2 = 5'd0; dlo = 4'h7;
      req_i = 3'b110; req_valid_i = 3'b110;
      for (int t = 0; t < 4; t++) begin
        wait_gnt($sformatf("rr%0d", t), 8);
        check($sformatf("rr%0d_gnt", t),  32'(gnt_o), 32'(exp_g[t]));
        check($sformatf("rr%0d_last", t), 32'(tx_last_o), 1);
        check($sformatf("rr%0d_data", t), 32'(tx_data_o), (t % 2 == 0) ? 32'hB7 : 32'hC7);
        to_pos();
        if (t < 3) begin
          to_neg();
          check($sformatf("rr%0d_gnt_drop", t), 32'(gnt_o), 0);
          to_pos();
        end
      end
      req_i = '0; req_valid_i = '0;
      repeat (4) to_pos();
    end

    // ---------------- backpressure: len 4, 5 stall cycles before byte 3 ----------------
    begin
      logic       bp_rdy[9];
      logic [3:0] bp_byte[9];
      bp_rdy[0] = 1'b1; bp_byte[0] = 4'h1;
      bp_rdy[1] = 1'b1; bp_byte[1] = 4'h2;
      for (int j = 2; j < 7; j++) begin bp_rdy[j] = 1'b0; bp_byte[j] = 4'h3; end
      bp_rdy[7] = 1'b1; bp_byte[7] = 4'h3;
      bp_rdy[8] = 1'b1; bp_byte[8] = 4'h4;
      hs_cnt = 0;
      len1 = 5'd4; req_i = 3'b010; req_valid_i = 3'b010; tx_ready_i = 1'b1; dlo = 4'h1;
      wait_gnt("bp", 8);
      req_i = '0;
      for (int j = 0; j < 9; j++) begin
        if (j > 0) begin
          tx_ready_i = bp_rdy[j]; dlo = bp_byte[j];
          to_neg();
        end
        check($sformatf("bp%0d_data", j),  32'(tx_data_o), 32'({4'hB, bp_byte[j]}));
        check($sformatf("bp%0d_ready", j), 32'(req_ready_o), bp_rdy[j] ? 32'b010 : 32'b000);
        check($sformatf("bp%0d_last", j),  32'(tx_last_o), 32'(bp_byte[j] == 4'h4));
        if (tx_valid_o && tx_ready_i) hs_cnt++;
        to_pos();
      end
      tx_ready_i = 1'b1; req_valid_i = '0;
      to_neg();
      check("bp_handshakes", 32'(hs_cnt), 4);
      check("bp_gnt_drop",   32'(gnt_o), 0);
      repeat (3) to_pos();
    end

    // ---------------- reset mid-transfer; pointer must return to requester 1 ----------------
    len1 = 5'd4; req_i = 3'b010; req_valid_i = 3'b010; dlo = 4'h1;
    wait_gnt("rm", 8);
    to_pos();
    dlo = 4'h2;
    to_pos();
    dlo = 4'h3;
    #2 rst = 1'b1;
    #1;
    check("rm_gnt",   32'(gnt_o), 0);
    check("rm_valid", 32'(tx_valid_o), 0);
    check("rm_last",  32'(tx_last_o), 0);
    check("rm_data",  32'(tx_data_o), 0);
    check("rm_busy",  32'(busy_o), 0);
    check("rm_ready", 32'(req_ready_o), 0);
    check("rm_abort", 32'(abort_o), 0);
    #3 rst = 1'b0;
    req_i = 3'b110; req_valid_i = 3'b010; dlo = 4'h1;
    wait_gnt("rm_after", 8);
    check("rm_after_gnt", 32'(gnt_o), 32'b010);
    req_i = '0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin
        dlo = 4'(k);
        to_neg();
      end
      check($sformatf("rm_b%0d_data", k),  32'(tx_data_o), 32'({4'hB, 4'(k)}));
      check($sformatf("rm_b%0d_valid", k), 32'(tx_valid_o), 1);
      check($sformatf("rm_b%0d_last", k),  32'(tx_last_o), 32'(k == 4));
      to_pos();
    end
    req_valid_i = '0;
    repeat (3) to_pos();

    // ---------------- stall after byte 1 ----------------
    len1 = 5'd4; len2 = 5'd1; req_i = 3'b010; req_valid_i = 3'b010; dlo = 4'h1;
    wait_gnt("to", 8);
    check("to_b1_data", 32'(tx_data_o), 32'hB1);
    to_pos();
    req_i = 3'b100; req_valid_i = 3'b000;
`ifdef SB_ARB_TIMEOUT_EN
    for (int s = 1; s <= 8; s++) begin
      to_neg();
      check($sformatf("to_s%0d_abort", s), 32'(abort_o), 32'(s == 8));
      check($sformatf("to_s%0d_gnt", s),   32'(gnt_o), 32'b010);
      check($sformatf("to_s%0d_valid", s), 32'(tx_valid_o), 0);
      to_pos();
    end
    to_neg();
    check("to_gnt_drop",    32'(gnt_o), 0);
    check("to_abort_pulse", 32'(abort_o), 0);
    to_pos();
`else
    for (int s = 1; s <= 12; s++) begin
      to_neg();
      check($sformatf("to_s%0d_abort", s), 32'(abort_o), 0);
      check($sformatf("to_s%0d_gnt", s),   32'(gnt_o), 32'b010);
      check($sformatf("to_s%0d_busy", s),  32'(busy_o), 1);
      to_pos();
    end
    req_valid_i = 3'b010;
    for (int k = 2; k <= 4; k++) begin
      dlo = 4'(k);
      to_neg();
      check($sformatf("to_b%0d_data", k), 32'(tx_data_o), 32'({4'hB, 4'(k)}));
      check($sformatf("to_b%0d_last", k), 32'(tx_last_o), 32'(k == 4));
      to_pos();
    end
`endif
    req_valid_i = 3'b100; dlo = 4'h9;
    wait_gnt("to_next", 10);
    check("to_next_gnt",  32'(gnt_o), 32'b100);
    check("to_next_data", 32'(tx_data_o), 32'hC9);
    check("to_next_last", 32'(tx_last_o), 1);
    to_pos();
    req_i = '0; req_valid_i = '0;
    repeat (4) to_pos();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
